// File: rtl/ni_out_buffer_param_pkg.sv
// Shared constants for the NI output flit buffer.
package ni_out_buffer_param_pkg;

  localparam int NI_FLIT_WIDTH_DEFAULT = 80;

endpackage

// File: rtl/ni_out_buffer_param_if.sv
// Handshake bundle between the NI packetizer, the output buffer and the switch port.
interface ni_out_buffer_param_if
  import ni_out_buffer_param_pkg::*;
#(
  parameter int FLIT_WIDTH = NI_FLIT_WIDTH_DEFAULT,
  parameter int LOG_DEPTH  = 3
);

  logic [FLIT_WIDTH-1:0] data_in;
  logic                  tail_in;
  logic                  write;
  logic                  full;
  logic                  almost_full;
  logic [LOG_DEPTH:0]    count;
  logic                  overflow;
  logic [FLIT_WIDTH-1:0] FLIT_out;
  logic                  TAIL_out;
  logic                  VALID_out;
  logic                  STALL_in;

  // Buffer side.
  modport slave (
    input  data_in, tail_in, write, STALL_in,
    output full, almost_full, count, overflow, FLIT_out, TAIL_out, VALID_out
  );

  // Packetizer/switch side.
  modport master (
    output data_in, tail_in, write, STALL_in,
    input  full, almost_full, count, overflow, FLIT_out, TAIL_out, VALID_out
  );

endinterface

// File: rtl/ni_out_buffer_param.sv
// First-word fall-through flit buffer between the NI packetizer and the switch.
// Optional packet-hold mode (offer flits only once a whole packet is stored): NI_OUTBUF_PKT_HOLD_EN.
module ni_out_buffer_param
  import ni_out_buffer_param_pkg::*;
#(
  parameter int FLIT_WIDTH = NI_FLIT_WIDTH_DEFAULT,
  parameter int DEPTH      = 6,
  parameter int LOG_DEPTH  = 3,
  parameter int AF_FREE    = 2
) (
  input logic                   clk,
  input logic                   rst,
  ni_out_buffer_param_if.slave  bus
);

  localparam logic [LOG_DEPTH-1:0] LAST_PTR  = LOG_DEPTH'(DEPTH - 1);
  localparam logic [LOG_DEPTH:0]   DEPTH_CNT = (LOG_DEPTH + 1)'(DEPTH);

  logic [FLIT_WIDTH-1:0] flitMem_q [DEPTH];
  logic [DEPTH-1:0]      tailMem_q;

  logic [LOG_DEPTH-1:0] rdPtr_q, rdPtr_d;
  logic [LOG_DEPTH-1:0] wrPtr_q, wrPtr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic        full;
  logic        valid;
  logic        push;
  logic        pop;
  logic        headTail;
  logic [31:0] freeEntries;

  assign full        = (count_q == DEPTH_CNT);
  assign freeEntries = 32'(DEPTH) - 32'(count_q);
  assign headTail    = tailMem_q[rdPtr_q];

`ifdef NI_OUTBUF_PKT_HOLD_EN
  logic [LOG_DEPTH:0] pktCnt_q, pktCnt_d;

  // A full buffer must still drain even without a tail, otherwise it deadlocks.
  assign valid = (count_q != '0) && ((pktCnt_q != '0) || full);

  always_comb begin
    pktCnt_d = pktCnt_q;
    case ({push && bus.tail_in, pop && headTail})
      2'b10:   pktCnt_d = pktCnt_q + 1'b1;
      2'b01:   pktCnt_d = pktCnt_q - 1'b1;
      default: pktCnt_d = pktCnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pktCnt_q <= '0;
    else     pktCnt_q <= pktCnt_d;
  end
`else
  assign valid = (count_q != '0);
`endif

  // Full is registered state, so a same-cycle pop never frees room for a write.
  assign push = bus.write && !full;
  assign pop  = valid && !bus.STALL_in;

  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.write & full);
    if (push) wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; stale entries are invisible behind VALID_out.
  always_ff @(posedge clk) begin
    if (push) begin
      flitMem_q[wrPtr_q] <= bus.data_in;
      tailMem_q[wrPtr_q] <= bus.tail_in;
    end
  end

  assign bus.FLIT_out    = flitMem_q[rdPtr_q];
  assign bus.TAIL_out    = headTail;
  assign bus.VALID_out   = valid;
  assign bus.full        = full;
  assign bus.almost_full = (freeEntries <= 32'(AF_FREE));
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_ni_out_buffer_param.sv
// Self-checking bench for ni_out_buffer_param: queue-based reference model plus directed literals.
// Define NI_OUTBUF_PKT_HOLD_EN for both bench and RTL to exercise packet-hold mode.
module tb_ni_out_buffer_param;

  localparam int FW      = 80;
  localparam int DEPTH   = 6;
  localparam int LOGD    = 3;
  localparam int AF_FREE = 2;

  typedef struct packed {
    logic          tail;
    logic [FW-1:0] data;
  } entry_t;

  logic clk;
  logic rst;

  ni_out_buffer_param_if #(.FLIT_WIDTH(FW), .LOG_DEPTH(LOGD)) bus ();

  ni_out_buffer_param #(
    .FLIT_WIDTH(FW),
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOGD),
    .AF_FREE   (AF_FREE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t modelQ[$];
  bit     modelOvf;
  int     checkCount;
  int     passCount;

  // Offer rule stated in terms of whole packets held in the queue.
  function automatic bit modelValid();
    int pkts;
    if (modelQ.size() == 0) return 1'b0;
`ifdef NI_OUTBUF_PKT_HOLD_EN
    pkts = 0;
    foreach (modelQ[i]) if (modelQ[i].tail) pkts++;
    return (pkts != 0) || (modelQ.size() == DEPTH);
`else
    pkts = 0;
    return 1'b1 | (pkts != 0);
`endif
  endfunction

  task automatic checkVal(input string name, input logic [95:0] act, input logic [95:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic modelStep(input logic w, input logic tl, input logic [FW-1:0] d,
                           input logic stall, input logic r);
    bit isFull;
    bit doPop;
    entry_t e;
    if (r) begin
      modelQ.delete();
      modelOvf = 1'b0;
      return;
    end
    isFull = (modelQ.size() == DEPTH);
    doPop  = modelValid() && !stall;
    if (w && isFull) modelOvf = 1'b1;
    if (doPop) void'(modelQ.pop_front());
    if (w && !isFull) begin
      e.tail = tl;
      e.data = d;
      modelQ.push_back(e);
    end
  endtask

  task automatic checkOutput();
    bit mv;
    mv = modelValid();
    checkVal("count", 96'(bus.count), 96'(modelQ.size()));
    checkVal("full", 96'(bus.full), 96'(modelQ.size() == DEPTH));
    checkVal("almost_full", 96'(bus.almost_full), 96'((DEPTH - modelQ.size()) <= AF_FREE));
    checkVal("overflow", 96'(bus.overflow), 96'(modelOvf));
    checkVal("VALID_out", 96'(bus.VALID_out), 96'(mv));
    if (mv && bus.VALID_out) begin
      checkVal("FLIT_out", 96'(bus.FLIT_out), 96'(modelQ[0].data));
      checkVal("TAIL_out", 96'(bus.TAIL_out), 96'(modelQ[0].tail));
    end
  endtask

  task automatic applyStimulus(input logic w, input logic tl, input logic [FW-1:0] d,
                               input logic stall, input logic r);
    bus.write    = w;
    bus.tail_in  = tl;
    bus.data_in  = d;
    bus.STALL_in = stall;
    rst          = r;
    modelStep(w, tl, d, stall, r);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic drainOrReset();
    for (int i = 0; i < 2 * DEPTH && modelQ.size() != 0; i++)
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    if (modelQ.size() != 0) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  function automatic logic [FW-1:0] randFlit();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  initial begin
    logic [FW-1:0] pattern;
    checkCount = 0;
    passCount  = 0;
    modelOvf   = 1'b0;
    pattern    = 80'h5A5A_0000_0000_0000_00A5;

    // Reset state
    applyStimulus(1'b1, 1'b1, randFlit(), 1'b0, 1'b1);
    checkVal("rst_count", 96'(bus.count), 96'd0);
    checkVal("rst_valid", 96'(bus.VALID_out), 96'd0);
    checkVal("rst_full", 96'(bus.full), 96'd0);
    checkVal("rst_af", 96'(bus.almost_full), 96'd0);

    // Single flit, fall-through latency 1
    applyStimulus(1'b1, 1'b1, pattern, 1'b0, 1'b0);
    checkVal("a5_valid", 96'(bus.VALID_out), 96'd1);
    checkVal("a5_flit", 96'(bus.FLIT_out), 96'(pattern));
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkVal("a5_count0", 96'(bus.count), 96'd0);

    // Fill under stall, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 80'(i + 16), 1'b1, 1'b0);
      checkVal("fill_af", 96'(bus.almost_full), 96'(i + 1 >= 4));
    end
    checkVal("fill_full", 96'(bus.full), 96'd1);
    checkVal("fill_count", 96'(bus.count), 96'd6);
    applyStimulus(1'b1, 1'b1, 80'hBAD, 1'b1, 1'b0);
    checkVal("ovf_set", 96'(bus.overflow), 96'd1);
    checkVal("ovf_count", 96'(bus.count), 96'd6);

    // Full with simultaneous write and pop: write dropped
    applyStimulus(1'b1, 1'b1, 80'hBAD2, 1'b0, 1'b0);
    checkVal("wrpop_count", 96'(bus.count), 96'd5);
    checkVal("wrpop_head", 96'(bus.FLIT_out), 96'd17);
    drainOrReset();

    // Mid-packet reset with count=3
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, randFlit(), 1'b1, 1'b0);
    checkVal("mid_count", 96'(bus.count), 96'd3);
    applyStimulus(1'b1, 1'b1, randFlit(), 1'b0, 1'b1);
    checkVal("mid_rst_count", 96'(bus.count), 96'd0);
    checkVal("mid_rst_valid", 96'(bus.VALID_out), 96'd0);
    checkVal("mid_rst_ovf", 96'(bus.overflow), 96'd0);
    applyStimulus(1'b1, 1'b1, pattern, 1'b0, 1'b0);
    checkVal("post_rst_flit", 96'(bus.FLIT_out), 96'(pattern));
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkVal("post_rst_count", 96'(bus.count), 96'd0);

    // Randomized traffic with pointer wrap and occasional reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), randFlit(),
                    ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) == 0));
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

`ifdef NI_OUTBUF_PKT_HOLD_EN
    // Tail withheld: nothing offered until the whole packet is stored
    applyStimulus(1'b1, 1'b0, 80'h101, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 80'h102, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      checkVal("hold_valid0", 96'(bus.VALID_out), 96'd0);
    end
    applyStimulus(1'b1, 1'b1, 80'h103, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkVal("hold_drain_valid", 96'(bus.VALID_out), 96'd1);
      checkVal("hold_drain_flit", 96'(bus.FLIT_out), 96'(80'h101 + i));
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    checkVal("hold_empty", 96'(bus.count), 96'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
